// File: rtl/instruction_decode_hs_pkg.sv
// Shared RV32I decode constants: opcode encodings, funct7 classes and the
// bit layout of the decoded-operation vector handed to execute.
package instruction_decode_hs_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;
  localparam logic [6:0] F7_MEXT = 7'h01;

  // decoded_op_de bit positions
  localparam int DOP_WE     = 0;
  localparam int DOP_JUMP   = 1;
  localparam int DOP_BRANCH = 2;
  localparam int DOP_LOAD   = 3;
  localparam int DOP_STORE  = 4;
  localparam int DOP_ALUIMM = 5;
  localparam int DOP_ALUREG = 6;
  localparam int DOP_LUI    = 7;
  localparam int DOP_AUIPC  = 8;
  localparam int DOP_FENCE  = 9;
  localparam int DOP_SYSTEM = 10;
  localparam int OPLEN      = 11;

endpackage

// File: rtl/instruction_decode_hs_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set on issue,
// cleared on writeback or when the issuing entry is flushed.
module instruction_decode_hs_scoreboard (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_en,
  input  logic [4:0] set_idx,
  input  logic       clr_en,
  input  logic [4:0] clr_idx,
  input  logic       flush_en,
  input  logic [4:0] flush_idx,
  input  logic [4:0] rs1sel,
  input  logic       rs1_used,
  input  logic [4:0] rs2sel,
  input  logic       rs2_used,
  output logic       hazard
);

  logic [31:0] r_sb;
  logic [31:0] w_sb_next;

  // Set is applied last so an issue beats a same-cycle writeback to that reg.
  always_comb begin
    w_sb_next = r_sb;
    if (clr_en)   w_sb_next[clr_idx]   = 1'b0;
    if (flush_en) w_sb_next[flush_idx] = 1'b0;
    if (set_en)   w_sb_next[set_idx]   = 1'b1;
    w_sb_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sb <= '0;
    else        r_sb <= w_sb_next;
  end

  assign hazard = (rs1_used & r_sb[rs1sel]) | (rs2_used & r_sb[rs2sel]);

endmodule

// File: rtl/instruction_decode_hs.sv
// RV32I decode stage with valid/ready on both sides, RAW scoreboard stall,
// flush of the output entry, illegal detection and optional M decode.
module instruction_decode_hs
  import instruction_decode_hs_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int USE_SB = 1,
  parameter int RV_M   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      inst,
  input  logic             inst_valid_fd,
  output logic             ready_fd,
  input  logic [XLEN-1:0]  curr_pc_fd,
  input  logic [XLEN-1:0]  next_pc_fd,
  output logic [4:0]       rs1sel,
  output logic [4:0]       rs2sel,
  input  logic [XLEN-1:0]  rs1data_rd,
  input  logic [XLEN-1:0]  rs2data_rd,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rdsel,
  input  logic             flush,
  input  logic             ready_ex,
  output logic             valid_de,
  output logic [XLEN-1:0]  imm,
  output logic [XLEN-1:0]  rs1data_de,
  output logic [XLEN-1:0]  rs2data_de,
  output logic [XLEN-1:0]  curr_pc_de,
  output logic [XLEN-1:0]  next_pc_de,
  output logic [3:0]       funct_alu,
  output logic [4:0]       rdsel_de,
  output logic [OPLEN-1:0] decoded_op_de,
  output logic             mext_de,
  output logic             illegal_de
);

  logic [6:0] w_opc, w_f7;
  logic [2:0] w_f3;
  logic w_lui, w_auipc, w_jal, w_jalr, w_branch, w_load, w_store;
  logic w_opimm, w_op, w_fence, w_system, w_known;
  logic w_mext, w_f7_ok, w_illegal, w_we, w_rs1_used, w_rs2_used;
  logic w_hazard, w_accept;
  logic [4:0]             w_rd;
  logic signed [31:0]     w_imm32;
  logic [XLEN-1:0]        w_imm;
  logic [3:0]             w_funct;
  logic [OPLEN-1:0]       w_dop;

  assign w_opc = inst[6:0];
  assign w_f3  = inst[14:12];
  assign w_f7  = inst[31:25];

  assign w_lui    = (w_opc == OPC_LUI);
  assign w_auipc  = (w_opc == OPC_AUIPC);
  assign w_jal    = (w_opc == OPC_JAL);
  assign w_jalr   = (w_opc == OPC_JALR);
  assign w_branch = (w_opc == OPC_BRANCH);
  assign w_load   = (w_opc == OPC_LOAD);
  assign w_store  = (w_opc == OPC_STORE);
  assign w_opimm  = (w_opc == OPC_OP_IMM);
  assign w_op     = (w_opc == OPC_OP);
  assign w_fence  = (w_opc == OPC_MISC_MEM);
  assign w_system = (w_opc == OPC_SYSTEM);
  assign w_known  = w_lui | w_auipc | w_jal | w_jalr | w_branch | w_load | w_store |
                    w_opimm | w_op | w_fence | w_system;

  assign w_mext    = (RV_M != 0) && w_op && (w_f7 == F7_MEXT);
  assign w_f7_ok   = (w_f7 == F7_BASE) || (w_f7 == F7_ALT) || w_mext;
  assign w_illegal = ~w_known | (w_op & ~w_f7_ok);
  assign w_we      = ~w_illegal & (w_lui | w_auipc | w_jal | w_jalr | w_load |
                                   w_opimm | w_op | w_system);
  assign w_rd      = w_we ? inst[11:7] : 5'd0;

  assign rs1sel     = w_lui ? 5'd0 : inst[19:15];
  assign rs2sel     = inst[24:20];
  assign w_rs1_used = ~(w_lui | w_auipc | w_jal);
  assign w_rs2_used = w_op | w_branch | w_store;

  always_comb begin
    w_imm32 = '0;
    if (w_lui | w_auipc)                w_imm32 = {inst[31:12], 12'b0};
    else if (w_jal)                     w_imm32 = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    else if (w_jalr | w_load | w_opimm) w_imm32 = {{20{inst[31]}}, inst[31:20]};
    else if (w_store)                   w_imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    else if (w_branch)                  w_imm32 = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  end
  assign w_imm = XLEN'(w_imm32);

  // Immediate shifts carry the arithmetic/logical select in inst[30]; other
  // OP-IMM encodings reuse that bit as immediate data, so it is masked there.
  always_comb begin
    w_funct = 4'd0;
    if (w_illegal)                    w_funct = 4'd0;
    else if (w_op)                    w_funct = {(w_mext ? 1'b0 : inst[30]), w_f3};
    else if (w_opimm)                 w_funct = {((w_f3 == 3'b101) & inst[30]), w_f3};
    else if (w_jalr | w_fence | w_system) w_funct = {1'b0, w_f3};
  end

  always_comb begin
    w_dop = '0;
    if (!w_illegal) begin
      w_dop[DOP_WE]     = w_we;
      w_dop[DOP_JUMP]   = w_jal | w_jalr;
      w_dop[DOP_BRANCH] = w_branch;
      w_dop[DOP_LOAD]   = w_load;
      w_dop[DOP_STORE]  = w_store;
      w_dop[DOP_ALUIMM] = w_opimm;
      w_dop[DOP_ALUREG] = w_op;
      w_dop[DOP_LUI]    = w_lui;
      w_dop[DOP_AUIPC]  = w_auipc;
      w_dop[DOP_FENCE]  = w_fence;
      w_dop[DOP_SYSTEM] = w_system;
    end
  end

  generate
    if (USE_SB != 0) begin : g_sb
      instruction_decode_hs_scoreboard u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_en    (w_accept & w_we),
        .set_idx   (w_rd),
        .clr_en    (wb_valid),
        .clr_idx   (wb_rdsel),
        .flush_en  (flush & valid_de),
        .flush_idx (rdsel_de),
        .rs1sel    (rs1sel),
        .rs1_used  (w_rs1_used),
        .rs2sel    (rs2sel),
        .rs2_used  (w_rs2_used),
        .hazard    (w_hazard)
      );
    end else begin : g_nosb
      assign w_hazard = 1'b0;
    end
  endgenerate

  assign ready_fd = ~flush & ~w_hazard & (~valid_de | ready_ex);
  assign w_accept = inst_valid_fd & ready_fd;

  // Output register stage: valid is elastic, payload loads only on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        valid_de <= 1'b0;
    else if (flush)    valid_de <= 1'b0;
    else if (w_accept) valid_de <= 1'b1;
    else if (ready_ex) valid_de <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm           <= '0;
      rs1data_de    <= '0;
      rs2data_de    <= '0;
      curr_pc_de    <= '0;
      next_pc_de    <= '0;
      funct_alu     <= '0;
      rdsel_de      <= '0;
      decoded_op_de <= '0;
      mext_de       <= 1'b0;
      illegal_de    <= 1'b0;
    end else if (w_accept) begin
      imm           <= w_imm;
      rs1data_de    <= rs1data_rd;
      rs2data_de    <= rs2data_rd;
      curr_pc_de    <= curr_pc_fd;
      next_pc_de    <= next_pc_fd;
      funct_alu     <= w_funct;
      rdsel_de      <= w_rd;
      decoded_op_de <= w_dop;
      mext_de       <= w_mext;
      illegal_de    <= w_illegal;
    end
  end

endmodule
